// File: rtl/y_stream_sink.sv
// Receive-side frame buffer for the convolver output stream: captures LENY signed
// samples, tracks their running sum and count, then holds the frame until released.
module y_stream_sink #(
  parameter int WIDTH = 8,
  parameter int LENY  = 5,
  parameter int ADDRY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       s_data_in_y,
  input  logic                   s_valid_y,
  output logic                   s_ready_y,
  input  logic                   hold_off,
  input  logic [ADDRY-1:0]       rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   frame_done,
  output logic [WIDTH+ADDRY-1:0] frame_sum,
  output logic [ADDRY-1:0]       sample_cnt,
  input  logic                   release_frame
);

  localparam int SUM_W = WIDTH + ADDRY;
  localparam logic [ADDRY-1:0] LAST_PTR = ADDRY'(LENY - 1);
  localparam logic [ADDRY:0]   LENY_W   = (ADDRY + 1)'(LENY);

  typedef enum logic {RECV, FULL} state_t;

  state_t           state_q;
  logic [ADDRY-1:0] wr_ptr_q;
  logic [SUM_W-1:0] frame_sum_q;
  logic [SUM_W-1:0] frame_sum_d;
  logic             frame_done_q;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] mem_q [2**ADDRY];
  logic             accept;

  assign s_ready_y   = (state_q == RECV) && !hold_off && !reset;
  assign accept      = s_valid_y && s_ready_y;
  assign frame_sum_d = frame_sum_q + {{ADDRY{s_data_in_y[WIDTH-1]}}, s_data_in_y};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; reset wins because accept is already gated by !reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RECV;
      wr_ptr_q     <= '0;
      frame_sum_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        RECV: begin
          if (accept) begin
            frame_sum_q <= frame_sum_d;
            if (wr_ptr_q == LAST_PTR) begin
              wr_ptr_q     <= '0;
              state_q      <= FULL;
              frame_done_q <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (release_frame) begin
            state_q      <= RECV;
            frame_done_q <= 1'b0;
            frame_sum_q  <= '0;
          end
        end
        default: state_q <= RECV;
      endcase
    end
  end

  // NOTE: the sample buffer is deliberately left out of reset; only the read
  // register is cleared. Reading before the write gives old-data on collisions.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= s_data_in_y;
    end
    if (reset) begin
      rd_data_q <= '0;
    end else if ({1'b0, rd_addr} < LENY_W) begin
      rd_data_q <= mem_q[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  // The write pointer doubles as the per-frame sample count.
  assign sample_cnt = wr_ptr_q;
  assign frame_sum  = frame_sum_q;
  assign frame_done = frame_done_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_y_stream_sink.sv
// Directed and randomized checks of y_stream_sink against a frame-level model
// (captured-sample array, running integer sum, count and a full flag).
module tb_y_stream_sink;

  localparam int WIDTH = 8;
  localparam int LENY  = 5;
  localparam int ADDRY = 3;
  localparam int DEPTH = 2 ** ADDRY;

  logic                   clk;
  logic                   reset;
  logic [WIDTH-1:0]       s_data_in_y;
  logic                   s_valid_y;
  logic                   s_ready_y;
  logic                   hold_off;
  logic [ADDRY-1:0]       rd_addr;
  logic [WIDTH-1:0]       rd_data;
  logic                   frame_done;
  logic [WIDTH+ADDRY-1:0] frame_sum;
  logic [ADDRY-1:0]       sample_cnt;
  logic                   release_frame;

  y_stream_sink #(.WIDTH(WIDTH), .LENY(LENY), .ADDRY(ADDRY)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_data_in_y  (s_data_in_y),
    .s_valid_y    (s_valid_y),
    .s_ready_y    (s_ready_y),
    .hold_off     (hold_off),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_done   (frame_done),
    .frame_sum    (frame_sum),
    .sample_cnt   (sample_cnt),
    .release_frame(release_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level reference model
  int mem_m [DEPTH];
  bit known [DEPTH];
  bit m_full = 1'b0;
  int m_cnt  = 0;
  int m_sum  = 0;
  int n_acc  = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit exp_rdy;
    bit rd_chk;
    int rd_exp;
    int ra;
    exp_rdy = !m_full && !hold_off && !reset;
    #1;
    check("s_ready_y", {31'b0, s_ready_y}, {31'b0, exp_rdy});
    @(posedge clk);
    ra     = int'(rd_addr);
    rd_chk = 1'b1;
    rd_exp = 0;
    if (!reset && ra < LENY) begin
      rd_chk = known[ra];
      rd_exp = mem_m[ra];
    end
    if (reset) begin
      m_full = 1'b0;
      m_cnt  = 0;
      m_sum  = 0;
    end else if (exp_rdy && s_valid_y) begin
      mem_m[m_cnt] = $signed(s_data_in_y);
      known[m_cnt] = 1'b1;
      m_sum        = m_sum + $signed(s_data_in_y);
      m_cnt        = m_cnt + 1;
      n_acc        = n_acc + 1;
      if (m_cnt == LENY) begin
        m_cnt  = 0;
        m_full = 1'b1;
      end
    end else if (m_full && release_frame) begin
      m_full = 1'b0;
      m_sum  = 0;
    end
    #1;
    check("frame_done", {31'b0, frame_done}, {31'b0, m_full});
    check("frame_sum", $signed(frame_sum), m_sum);
    check("sample_cnt", {29'b0, sample_cnt}, m_cnt);
    if (rd_chk) check($sformatf("rd_data@%0d", ra), $signed(rd_data), rd_exp);
    @(negedge clk);
  endtask

  task automatic cyc(input bit v, input int d, input bit h, input bit rel,
                     input bit rst, input int ra);
    s_valid_y     = v;
    s_data_in_y   = WIDTH'(d);
    hold_off      = h;
    release_frame = rel;
    reset         = rst;
    rd_addr       = ADDRY'(ra);
    tick();
  endtask

  task automatic read_chk(input int a, input int exp);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, a);
    check($sformatf("readback@%0d", a), $signed(rd_data), exp);
  endtask

  int d1 [LENY] = '{3, -2, 7, 0, 127};
  int d2 [LENY] = '{-5, 9, -100, 44, 1};
  int idx;
  int acc0;

  initial begin
    reset = 1'b1; s_valid_y = 1'b0; s_data_in_y = '0; hold_off = 1'b0;
    release_frame = 1'b0; rd_addr = '0;
    @(negedge clk);

    // Reset state
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 55, 0, 0, 1, 0);
    check("rst_done", {31'b0, frame_done}, 0);
    check("rst_sum", $signed(frame_sum), 0);
    check("rst_rd_data", $signed(rd_data), 0);

    // Back-to-back frame
    for (int i = 0; i < LENY; i++) cyc(1, d1[i], 0, 0, 0, 7);
    cyc(1, 99, 0, 0, 0, 0);
    check("f1_done", {31'b0, frame_done}, 1);
    check("f1_sum", $signed(frame_sum), 135);
    check("f1_ready", {31'b0, s_ready_y}, 0);
    for (int a = 0; a < LENY; a++) read_chk(a, d1[a]);
    read_chk(6, 0);

    // Release, then toggling valid with a hold_off window mid-frame
    cyc(0, 0, 0, 1, 0, 0);
    idx = 0;
    for (int c = 0; c < 40 && idx < LENY; c++) begin
      acc0 = n_acc;
      cyc((c % 2) == 0, d1[idx], (c >= 3 && c < 6), 0, 0, 0);
      if (n_acc != acc0) idx++;
    end
    check("f2_sum", $signed(frame_sum), 135);
    check("f2_done", {31'b0, frame_done}, 1);
    for (int a = 0; a < LENY; a++) read_chk(a, d1[a]);

    // Full frame ignores a persistent -128 offer
    for (int c = 0; c < 10; c++) cyc(1, -128, 0, 0, 0, 1);
    check("full_sum_frozen", $signed(frame_sum), 135);
    cyc(1, -128, 0, 1, 0, 1);
    cyc(1, -128, 0, 0, 0, 0);
    check("rel_first_sum", $signed(frame_sum), -128);
    check("rel_first_cnt", {29'b0, sample_cnt}, 1);
    for (int c = 0; c < LENY - 1; c++) cyc(1, -128, 0, 0, 0, 0);
    check("neg_sum", $signed(frame_sum), -640);
    check("neg_done", {31'b0, frame_done}, 1);
    read_chk(0, -128);
    read_chk(4, -128);

    // Reset after 3 accepts, then a full frame from address 0
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, d2[i], 0, 0, 0, 0);
    cyc(1, 77, 0, 0, 1, 0);
    check("midrst_cnt", {29'b0, sample_cnt}, 0);
    check("midrst_sum", $signed(frame_sum), 0);
    check("midrst_done", {31'b0, frame_done}, 0);
    for (int i = 0; i < LENY; i++) cyc(1, d2[LENY - 1 - i], 0, 0, 0, 0);
    check("postrst_sum", $signed(frame_sum), -51);
    for (int a = 0; a < LENY; a++) read_chk(a, d2[LENY - 1 - a]);

    // release_frame in RECV is ignored
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 20, 0, 0, 0, 0);
    cyc(1, -7, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("recv_rel_cnt", {29'b0, sample_cnt}, 2);
    check("recv_rel_sum", $signed(frame_sum), 13);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      cyc(($urandom % 4) != 0, int'($urandom_range(0, 255)) - 128,
          ($urandom % 4) == 0, ($urandom % 6) == 0,
          ($urandom % 64) == 0, int'($urandom_range(0, DEPTH - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
